// File: rtl/tmu2_hsched_if.sv
// ============================================================================
// Module  : tmu2_hsched_if
// Brief   : Job handshake bundle between two scanline sources, the
//           horizontal scheduler and the tmu2 horizontal interpolator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface tmu2_hsched_if #(
  parameter int JOB_W = 135
);
  logic             s0_stb_i;
  logic             s0_ack_o;
  logic [JOB_W-1:0] s0_job_i;
  logic             s1_stb_i;
  logic             s1_ack_o;
  logic [JOB_W-1:0] s1_job_i;
  logic             pipe_stb_o;
  logic             pipe_ack_i;
  logic [JOB_W-1:0] job_o;
  logic             src_o;

  // Environment side: drives jobs and the interpolator acknowledge.
  modport master (
    output s0_stb_i, s0_job_i, s1_stb_i, s1_job_i, pipe_ack_i,
    input  s0_ack_o, s1_ack_o, pipe_stb_o, job_o, src_o
  );

  // Scheduler side.
  modport slave (
    input  s0_stb_i, s0_job_i, s1_stb_i, s1_job_i, pipe_ack_i,
    output s0_ack_o, s1_ack_o, pipe_stb_o, job_o, src_o
  );
endinterface

`default_nettype wire

// File: rtl/tmu2_hsched.sv
// ============================================================================
// Module  : tmu2_hsched
// Brief   : Round-robin arbiter feeding one registered job at a time from two
//           sources into the horizontal interpolator, tagged with its source.
//           Optional per-source grant counters: define TMU2_HSCHED_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tmu2_hsched #(
  parameter int JOB_W = 135
) (
  input  wire logic        sys_clk,
  input  wire logic        sys_rst,
  output logic             busy,
  input  wire logic        hinterp_busy_i,
`ifdef TMU2_HSCHED_STATS_EN
  input  wire logic        stat_clr_i,
  output logic [15:0]      stat_s0_o,
  output logic [15:0]      stat_s1_o,
`endif
  tmu2_hsched_if.slave     bus
);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_ISSUE = 1'b1;

  logic [0:0]       r_state;
  logic             r_last_grant;
  logic [JOB_W-1:0] r_job;
  logic             r_src;
  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;

  // On contention the source that was not granted last wins.
  assign w_idle   = (r_state == c_ST_IDLE);
  assign w_grant0 = w_idle & bus.s0_stb_i & (~bus.s1_stb_i | r_last_grant);
  assign w_grant1 = w_idle & bus.s1_stb_i & (~bus.s0_stb_i | ~r_last_grant);

  assign bus.s0_ack_o   = w_grant0;
  assign bus.s1_ack_o   = w_grant1;
  assign bus.pipe_stb_o = (r_state == c_ST_ISSUE);
  assign bus.job_o      = r_job;
  assign bus.src_o      = r_src;
  assign busy           = (r_state == c_ST_ISSUE) | hinterp_busy_i;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= c_ST_IDLE;
      r_last_grant <= 1'b1;
      r_job        <= '0;
      r_src        <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_grant0 | w_grant1) begin
            r_job        <= w_grant1 ? bus.s1_job_i : bus.s0_job_i;
            r_src        <= w_grant1;
            r_last_grant <= w_grant1;
            r_state      <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          if (bus.pipe_ack_i) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

`ifdef TMU2_HSCHED_STATS_EN
  logic [15:0] r_stat_s0;
  logic [15:0] r_stat_s1;

  // Clear wins over a same-cycle grant; counters wrap naturally.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_stat_s0 <= '0;
      r_stat_s1 <= '0;
    end else if (stat_clr_i) begin
      r_stat_s0 <= '0;
      r_stat_s1 <= '0;
    end else begin
      if (w_grant0) r_stat_s0 <= r_stat_s0 + 16'd1;
      if (w_grant1) r_stat_s1 <= r_stat_s1 + 16'd1;
    end
  end

  assign stat_s0_o = r_stat_s0;
  assign stat_s1_o = r_stat_s1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tmu2_hsched.sv
// ============================================================================
// Module  : tb_tmu2_hsched
// Brief   : Directed scoreboard bench for tmu2_hsched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmu2_hsched;
  localparam int JOB_W = 135;

  typedef struct packed {
    logic             src;
    logic [JOB_W-1:0] job;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic busy;
  logic hinterp_busy_i = 1'b0;
`ifdef TMU2_HSCHED_STATS_EN
  logic        stat_clr_i = 1'b0;
  logic [15:0] stat_s0_o;
  logic [15:0] stat_s1_o;
`endif

  tmu2_hsched_if #(.JOB_W(JOB_W)) bus ();

  tmu2_hsched #(.JOB_W(JOB_W)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .busy           (busy),
    .hinterp_busy_i (hinterp_busy_i),
`ifdef TMU2_HSCHED_STATS_EN
    .stat_clr_i     (stat_clr_i),
    .stat_s0_o      (stat_s0_o),
    .stat_s1_o      (stat_s1_o),
`endif
    .bus            (bus)
  );

  always #5 sys_clk = ~sys_clk;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic chk(input string name, input logic [JOB_W:0] act, input logic [JOB_W:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  task automatic expect_job(input logic s, input logic [JOB_W-1:0] j);
    exp_t e;
    e.src = s;
    e.job = j;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
  endtask

  // Monitor: every accepted issue is matched against the scoreboard queue.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (bus.pipe_stb_o && bus.pipe_ack_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("issue_src", bus.src_o, e.src);
          chk("issue_job", bus.job_o, e.job);
        end
      end
      if (bus.s0_ack_o || bus.s1_ack_o) begin
        chk("ack_onehot", bus.s0_ack_o & bus.s1_ack_o, 1'b0);
        chk("ack_in_issue", bus.pipe_stb_o, 1'b0);
      end
    end
  end

  initial begin
    bus.s0_stb_i   = 1'b0;
    bus.s1_stb_i   = 1'b0;
    bus.s0_job_i   = '0;
    bus.s1_job_i   = '0;
    bus.pipe_ack_i = 1'b0;

    // Reset state
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_pipe_stb", bus.pipe_stb_o, 1'b0);
    chk("rst_src", bus.src_o, 1'b0);
    chk("rst_job", bus.job_o, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_acks", {bus.s0_ack_o, bus.s1_ack_o}, 2'b00);
    step();
    sys_rst = 1'b0;

    // Single s0 job held for 5 cycles before the interpolator takes it
    bus.s0_job_i = 135'h1A5;
    bus.s0_stb_i = 1'b1;
    expect_job(1'b0, 135'h1A5);
    @(negedge sys_clk);
    chk("t1_s0_ack", bus.s0_ack_o, 1'b1);
    chk("t1_s1_ack", bus.s1_ack_o, 1'b0);
    step();
    bus.s0_stb_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("t1_hold_stb", bus.pipe_stb_o, 1'b1);
      chk("t1_hold_job", bus.job_o, 135'h1A5);
      chk("t1_hold_src", bus.src_o, 1'b0);
      chk("t1_hold_acks", {bus.s0_ack_o, bus.s1_ack_o}, 2'b00);
      chk("t1_hold_busy", busy, 1'b1);
    end
    step();
    bus.pipe_ack_i = 1'b1;
    step();
    @(negedge sys_clk);
    chk("t1_back_idle", bus.pipe_stb_o, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);

    // Both sources persistent after reset: 0,1,0,1
    pulse_reset();
    bus.s0_job_i = 135'h111;
    bus.s1_job_i = 135'h222;
    expect_job(1'b0, 135'h111);
    expect_job(1'b1, 135'h222);
    expect_job(1'b0, 135'h111);
    expect_job(1'b1, 135'h222);
    bus.s0_stb_i = 1'b1;
    bus.s1_stb_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (i % 2 == 0) begin
        chk("t2_s0_ack", bus.s0_ack_o, (i % 4 == 0));
        chk("t2_s1_ack", bus.s1_ack_o, (i % 4 == 2));
      end else begin
        chk("t2_issue_stb", bus.pipe_stb_o, 1'b1);
      end
      step();
    end
    bus.s0_stb_i = 1'b0;
    bus.s1_stb_i = 1'b0;

    // s1 alone twice, then contention: s0 must win
    bus.s1_job_i = 135'h333;
    expect_job(1'b1, 135'h333);
    expect_job(1'b1, 135'h333);
    bus.s1_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (i % 2 == 0) chk("t3_s1_ack", {bus.s0_ack_o, bus.s1_ack_o}, 2'b01);
      step();
    end
    bus.s0_job_i = 135'h444;
    bus.s0_stb_i = 1'b1;
    expect_job(1'b0, 135'h444);
    @(negedge sys_clk);
    chk("t3_s0_wins", {bus.s0_ack_o, bus.s1_ack_o}, 2'b10);
    step();
    bus.s0_stb_i = 1'b0;
    bus.s1_stb_i = 1'b0;
    step();

    // Asynchronous reset in the middle of an issue
    bus.pipe_ack_i = 1'b0;
    bus.s0_job_i   = 135'h666;
    bus.s0_stb_i   = 1'b1;
    step();
    bus.s0_stb_i = 1'b0;
    @(negedge sys_clk);
    chk("t4_pre_stb", bus.pipe_stb_o, 1'b1);
    @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    #1;
    chk("t4_async_stb", bus.pipe_stb_o, 1'b0);
    chk("t4_async_busy", busy, 1'b0);
    chk("t4_async_job", bus.job_o, '0);
    step();
    sys_rst        = 1'b0;
    bus.pipe_ack_i = 1'b1;
    bus.s1_job_i   = 135'h555;
    bus.s1_stb_i   = 1'b1;
    expect_job(1'b1, 135'h555);
    @(negedge sys_clk);
    chk("t4_s1_ack", {bus.s0_ack_o, bus.s1_ack_o}, 2'b01);
    step();
    bus.s1_stb_i = 1'b0;
    @(negedge sys_clk);
    chk("t4_src", bus.src_o, 1'b1);
    step();

    // busy follows the interpolator while idle
    hinterp_busy_i = 1'b1;
    #1;
    chk("t5_busy_hi", busy, 1'b1);
    hinterp_busy_i = 1'b0;
    #1;
    chk("t5_busy_lo", busy, 1'b0);

`ifdef TMU2_HSCHED_STATS_EN
    // Grant counters: 3 x s0, 2 x s1, then clear against an s0 grant
    pulse_reset();
    bus.s0_job_i = 135'h777;
    bus.s1_job_i = 135'h888;
    expect_job(1'b0, 135'h777);
    expect_job(1'b1, 135'h888);
    expect_job(1'b0, 135'h777);
    expect_job(1'b1, 135'h888);
    expect_job(1'b0, 135'h777);
    bus.s0_stb_i = 1'b1;
    bus.s1_stb_i = 1'b1;
    repeat (9) step();
    bus.s0_stb_i = 1'b0;
    bus.s1_stb_i = 1'b0;
    step();
    @(negedge sys_clk);
    chk("st_s0_cnt", stat_s0_o, 16'd3);
    chk("st_s1_cnt", stat_s1_o, 16'd2);
    step();
    stat_clr_i   = 1'b1;
    bus.s0_stb_i = 1'b1;
    expect_job(1'b0, 135'h777);
    step();
    stat_clr_i   = 1'b0;
    bus.s0_stb_i = 1'b0;
    @(negedge sys_clk);
    chk("st_clr_s0", stat_s0_o, 16'd0);
    chk("st_clr_s1", stat_s1_o, 16'd0);
    step();
`endif

    repeat (2) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
